// File: rtl/ffo_rr_arbiter.sv
// Round-robin arbiter: circular find-first-one from a rotating pointer, with a
// hold-until-done grant and a watchdog that forces release after tmo cycles.
module ffo_rr_arbiter #(
  parameter int w   = 4,
  parameter int tmo = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [0:w-1]         req,
  input  logic                 done,
  output logic [0:w-1]         gnt,
  output logic                 v,
  output logic [0:$clog2(w)-1] p,
  output logic                 err
);

  localparam int PW = $clog2(w);
  localparam int CW = $clog2(tmo + 1);
  localparam logic [PW:0]   W_EXT    = (PW + 1)'(w);
  localparam logic [PW-1:0] P_LAST   = PW'(w - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(tmo - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(tmo);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [0:w-1]  gnt_q, gnt_d;
  logic          v_q, v_d;
  logic [PW-1:0] p_q, p_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW:0]   search;

  // Returns {found, index}; scanning downward lets the lowest offset win.
  function automatic logic [PW:0] ffo_circ(input logic [0:w-1] r,
                                           input logic [PW-1:0] start);
    logic [PW:0] res;
    logic [PW:0] idx;
    res = '0;
    for (int k = w - 1; k >= 0; k--) begin
      idx = {1'b0, start} + (PW + 1)'(k);
      if (idx >= W_EXT) idx = idx - W_EXT;
      if (r[idx[PW-1:0]]) res = {1'b1, idx[PW-1:0]};
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    v_d     = v_q;
    p_d     = p_q;
    ptr_d   = ptr_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    search  = ffo_circ(req, ptr_q);
    case (state_q)
      IDLE: begin
        if (search[PW]) begin
          state_d                 = GRANT;
          gnt_d                   = '0;
          gnt_d[search[PW-1:0]]   = 1'b1;
          v_d                     = 1'b1;
          p_d                     = search[PW-1:0];
          cnt_d                   = '0;
        end
      end
      GRANT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        // done beats withdrawal beats watchdog; only the watchdog flags err
        if (done || !req[p_q] || (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          gnt_d   = '0;
          v_d     = 1'b0;
          ptr_d   = (p_q == P_LAST) ? '0 : p_q + PW'(1);
          err_d   = !done && req[p_q];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      v_q     <= 1'b0;
      p_q     <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      v_q     <= v_d;
      p_q     <= p_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt = gnt_q;
  assign v   = v_q;
  assign p   = p_q;
  assign err = err_q;

endmodule

// File: tb/tb_ffo_rr_arbiter.sv
// Scoreboard bench for ffo_rr_arbiter: a w=4 and a w=3 instance, directed grants
// with hand-computed expected index, grant length and err flag.
module tb_ffo_rr_arbiter;

  typedef struct {
    int p;
    int len;
    int err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst4_n, rst3_n;
  logic [0:3] req4, gnt4;
  logic       done4, v4, err4;
  logic [0:1] p4;
  logic [0:2] req3, gnt3;
  logic       done3, v3, err3;
  logic [0:1] p3;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp4[$];
  exp_t exp3[$];
  logic in4 = 1'b0, in3 = 1'b0;
  int   gp4, len4, gp3, len3;

  ffo_rr_arbiter #(.w(4), .tmo(8)) dut4 (
    .clk(clk), .rst_n(rst4_n), .req(req4), .done(done4),
    .gnt(gnt4), .v(v4), .p(p4), .err(err4)
  );

  ffo_rr_arbiter #(.w(3), .tmo(8)) dut3 (
    .clk(clk), .rst_n(rst3_n), .req(req3), .done(done3),
    .gnt(gnt3), .v(v3), .p(p3), .err(err3)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got no DUT response, expected one within bound (t=%0t)", nm, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: record a grant on v rising, compare against the queue on v falling.
  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst4_n) in4 = 1'b0;
    else if (v4) begin
      if (!in4) begin
        in4 = 1'b1;
        gp4 = int'(p4);
        len4 = 1;
        check("gnt4_onehot", int'(gnt4), int'(4'b1000 >> gp4));
      end else len4++;
    end else if (in4) begin
      in4 = 1'b0;
      if (exp4.size() == 0) note_fail("gnt4_unexpected");
      else begin
        e = exp4.pop_front();
        check("p4", gp4, e.p);
        check("len4", len4, e.len);
        check("err4", int'(err4), e.err);
      end
    end else check("err4_idle", int'(err4), 0);
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (!rst3_n) in3 = 1'b0;
    else if (v3) begin
      if (!in3) begin
        in3 = 1'b1;
        gp3 = int'(p3);
        len3 = 1;
        check("gnt3_onehot", int'(gnt3), int'(3'b100 >> gp3));
      end else len3++;
    end else if (in3) begin
      in3 = 1'b0;
      if (exp3.size() == 0) note_fail("gnt3_unexpected");
      else begin
        e = exp3.pop_front();
        check("p3", gp3, e.p);
        check("len3", len3, e.len);
        check("err3", int'(err3), e.err);
      end
    end else check("err3_idle", int'(err3), 0);
  end

  // dn: grant cycle in which done is pulsed; wd: cycle in which req drops (0 = never)
  task automatic grant4(input logic [0:3] r, input int dn, input int wd,
                        input int ep, input int el, input int ee);
    int n;
    exp4.push_back('{p: ep, len: el, err: ee});
    req4 = r;
    n = 0;
    while (!v4 && n < 20) begin tick(); n++; end
    if (!v4) begin note_fail("grant4_wait"); void'(exp4.pop_back()); return; end
    n = 1;
    while (v4 && n < 40) begin
      if (n == dn) done4 = 1'b1;
      if (n == wd) req4 = '0;
      tick();
      done4 = 1'b0;
      n++;
    end
    if (v4) note_fail("release4_wait");
  endtask

  task automatic grant3(input logic [0:2] r, input int dn,
                        input int ep, input int el, input int ee);
    int n;
    exp3.push_back('{p: ep, len: el, err: ee});
    req3 = r;
    n = 0;
    while (!v3 && n < 20) begin tick(); n++; end
    if (!v3) begin note_fail("grant3_wait"); void'(exp3.pop_back()); return; end
    n = 1;
    while (v3 && n < 40) begin
      if (n == dn) done3 = 1'b1;
      tick();
      done3 = 1'b0;
      n++;
    end
    if (v3) note_fail("release3_wait");
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish in time");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    rst4_n = 1'b0; rst3_n = 1'b0;
    req4 = '0; req3 = '0; done4 = 1'b0; done3 = 1'b0;
    tick(); tick();
    check("rst_v4", int'(v4), 0);
    check("rst_gnt3", int'(gnt3), 0);
    rst4_n = 1'b1; rst3_n = 1'b1;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_v4", int'(v4), 0);
      check("idle_gnt4", int'(gnt4), 0);
      check("idle_p4", int'(p4), 0);
      check("idle_err4", int'(err4), 0);
    end

    // Full request vector: strict rotation
    grant4(4'b1111, 3, 0, 0, 3, 0);
    grant4(4'b1111, 3, 0, 1, 3, 0);
    grant4(4'b1111, 3, 0, 2, 3, 0);
    grant4(4'b1111, 3, 0, 3, 3, 0);
    grant4(4'b1111, 3, 0, 0, 3, 0);

    // ptr=1 -> grant 2 moves ptr to 3, then wrap-around search
    grant4(4'b0010, 3, 0, 2, 3, 0);
    grant4(4'b1100, 3, 0, 0, 3, 0);
    grant4(4'b1100, 3, 0, 1, 3, 0);

    // Watchdog: 8 cycles then err; search resumes at index 3
    grant4(4'b0010, 0, 0, 2, 8, 1);
    grant4(4'b1111, 3, 0, 3, 3, 0);

    // Withdrawal on cycle 3, then ptr must be 2
    grant4(4'b0100, 0, 3, 1, 3, 0);
    grant4(4'b1111, 3, 0, 2, 3, 0);

    // done on the timeout cycle: no err
    grant4(4'b0001, 8, 0, 3, 8, 0);

    // done while idle is ignored
    req4 = '0;
    done4 = 1'b1;
    tick();
    done4 = 1'b0;
    tick();
    check("idle_done_v4", int'(v4), 0);
    check("idle_done_err4", int'(err4), 0);

    // Non-power-of-two w=3
    grant3(3'b111, 3, 0, 3, 0);
    grant3(3'b111, 3, 1, 3, 0);
    grant3(3'b111, 3, 2, 3, 0);
    grant3(3'b111, 3, 0, 3, 0);

    // Async reset mid-grant
    req3 = 3'b111;
    n = 0;
    while (!v3 && n < 20) begin tick(); n++; end
    check("pre_rst_v3", int'(v3), 1);
    check("pre_rst_p3", int'(p3), 1);
    tick();
    #2 rst3_n = 1'b0;
    #1;
    check("async_rst_v3", int'(v3), 0);
    check("async_rst_gnt3", int'(gnt3), 0);
    check("async_rst_p3", int'(p3), 0);
    check("async_rst_err3", int'(err3), 0);
    tick();
    rst3_n = 1'b1;
    check("post_rst_v3", int'(v3), 0);
    grant3(3'b111, 3, 0, 3, 0);
    req3 = '0;

    tick(); tick();
    check("exp4_left", exp4.size(), 0);
    check("exp3_left", exp3.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ffo_rr_arbiter.md
Name: ffo_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among w requesters.
- Priority search is a circular find-first-one: the lowest index at or after a rotating pointer wins, wrapping w-1 -> 0.
- Provides a registered one-hot grant plus encoded grant index/valid in the same b/v/p style as the combinational find-first-one datapath.
- Includes a hold-until-done handshake and a watchdog that reclaims a stuck grant.

Parameters:
- w, 4, number of requesters; legal range 2..32; need not be a power of two.
- tmo, 8, maximum grant duration in cycles before forced release; legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  [0:w-1]  request vector; index 0 = bit 0 (leftmost); level-sensitive.
- done  input  1  single-cycle release pulse from the current grant holder.
- gnt  output  [0:w-1]  one-hot grant, registered.
- v  output  1  grant valid, registered; equals |gnt.
- p  output  [0:$clog2(w)-1]  index of granted requester; valid only when v=1, holds last value otherwise.
- err  output  1  one-cycle pulse on watchdog forced release.

Behaviour:
- Reset (async, rst_n=0): gnt=0, v=0, p=0, err=0, state=IDLE, priority pointer ptr=0, watchdog cnt=0. Outputs clear immediately, without waiting for clk. Reset mid-grant drops the grant the same way.
- States: IDLE, GRANT.
- IDLE, req==0: remain in IDLE; outputs unchanged except err=0.
- IDLE, req!=0: winner = first set bit scanning indices ptr, ptr+1, ..., w-1, 0, ..., ptr-1.
  - At the same edge: gnt=onehot(winner), v=1, p=winner, cnt=0, state goes to GRANT.
  - Latency: req sampled at edge N gives grant visible after edge N.
- GRANT, per cycle: cnt increments, saturating; gnt/v/p hold.
- GRANT release causes, evaluated at each edge in priority order:
  1. done=1: normal release.
  2. req[p]=0 (holder withdrew): normal release, no err.
  3. cnt==tmo-1 with neither of the above: forced release, err=1 for exactly one cycle.
- On any release:
  - gnt=0 and v=0 at that edge; p holds its value.
  - ptr = (p+1) mod w, so w-1 wraps to 0.
  - state goes to IDLE.
- Minimum gap between consecutive grants is one IDLE cycle, so grants never occur back-to-back.
- Done in the same cycle as timeout: done wins, err stays 0.
- done while in IDLE is ignored.
- Other req bits changing during GRANT are ignored; only req[p] is observed.
- A requester that keeps req asserted after release is re-granted only when the search from the new ptr reaches it. This guarantees every requester is served within w grants.
- Non-power-of-two w: ptr and p never exceed w-1; the wrap is modulo w, not modulo 2^$clog2(w).
- Maximum grant length is tmo cycles with v=1. With tmo=1, a grant lasts exactly one cycle unless done or withdrawal occurs first; no err is raised when done arrives.
- cnt width is $clog2(tmo+1). It resets to 0 on every grant entry.
- Exactly one gnt bit is high whenever v=1; gnt=0 whenever v=0.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles: v=0, gnt=0000, p=0, err=0 throughout. Assert rst_n=0 between clock edges: outputs clear before the next clk edge.
- req=4'b1111, done pulsed 2 cycles after each grant: grant order p=0,1,2,3,0. Each grant has v=1 for 3 cycles followed by one IDLE cycle.
- ptr=3 (after granting index 2), req=4'b1100 (bits 0,1 set): next grant is p=0 (wrap). After release, req=4'b1100 again: grant is p=1.
- tmo=8, grant p=2, no done, req[2] held high: v=1 for exactly 8 cycles, then v=0 with err=1 for one cycle; next grant starts search from index 3.
- Grant p=1, then deassert req[1] on cycle 3: release at that edge with err=0; ptr becomes 2. Separately, done and the timeout cycle coincide: release with err=0.
- w=3 variant, req=3'b111 with repeated done: p cycles 0,1,2,0 and never reaches 3. Reset asserted mid-GRANT: v=0 and gnt=000 immediately; after reset, first grant with req=111 is p=0.
